cpu_serial_port: RTL and testbench



---
 rtl/serial_pkg.sv | 39 +++
 rtl/serial_tx_fifo.sv | 61 ++++++
 rtl/cpu_serial_port.sv | 248 ++++++++++++++++++++++++
 tb/tb_cpu_serial_port.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the CPU serial transmitter: register offsets,
// STATUS bit positions, shifter state encoding and frame constants.
// Build option: SERIAL_PARITY_EN adds an even-parity bit to every frame.
package serial_pkg;

  localparam logic [3:0] OFS_TXDATA = 4'd0;
  localparam logic [3:0] OFS_STATUS = 4'd1;
  localparam logic [3:0] OFS_DIV    = 4'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef SERIAL_PARITY_EN
  localparam int   FRAME_BITS   = 11;
  localparam logic PARITY_BUILD = 1'b1;
`else
  localparam int   FRAME_BITS   = 10;
  localparam logic PARITY_BUILD = 1'b0;
`endif

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for the serial shifter.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module serial_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards everything queued.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_serial_port.sv
// Memory-mapped 8N1 serial transmitter on the 12-bit address / 8-bit data bus.
// Window of 16 bytes at BASE_ADDR: TXDATA (push), STATUS, DIV.
// Build option: SERIAL_PARITY_EN inserts an even-parity bit before the stop bit.
module cpu_serial_port
  import serial_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR   = 12'hFF0,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  DEFAULT_DIV = 8'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic        write,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  output logic        tx
);

  logic       w_sel;
  logic [3:0] w_ofs;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;
  logic       w_busy;
  logic       w_bit_end;
  logic       w_ovf_set;
  logic       w_ovf_clr;
  logic       w_line;
  logic [7:0] w_status;

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic [7:0] r_div;
  logic [7:0] r_bit_div;
  logic [7:0] w_bit_div_nxt;
  logic [7:0] r_div_cnt;
  logic [7:0] w_div_cnt_nxt;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic       r_ovf;
  logic       r_tx;

  assign w_sel     = (addr[11:4] == BASE_ADDR[11:4]);
  assign w_ofs     = addr[3:0];
  assign w_push    = w_sel && write && (w_ofs == OFS_TXDATA);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = w_sel && write && (w_ofs == OFS_STATUS) && wdata[ST_OVF];
  assign w_busy    = (r_state != S_IDLE);
  assign w_bit_end = (r_div_cnt == r_bit_div);
  assign rdata_oe  = w_sel && !write && !reset;
  assign tx        = r_tx;

  serial_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (wdata),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef SERIAL_PARITY_EN
  logic r_par;

  // Parity of the byte being shifted, captured when it leaves the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= even_parity(w_head);
    end else begin
      r_par <= r_par;
    end
  end
`endif

  // Shifter next-state logic: bit timing, bit counting and FIFO pops.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_bit_div_nxt = r_bit_div;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_bit_div_nxt = r_div;
          w_div_cnt_nxt = 8'd0;
          w_state_nxt   = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_div_cnt_nxt = 8'd0;
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_div_cnt_nxt = 8'd0;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_div_cnt_nxt = 8'd0;
          w_state_nxt   = S_STOP;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_div_cnt_nxt = 8'd0;
          // Chain straight into the next frame so queued bytes leave without a gap.
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_div_nxt = r_div;
            w_state_nxt   = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Line level for the current shifter state; registered one cycle later.
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_IDLE:   w_line = 1'b1;
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[0];
`ifdef SERIAL_PARITY_EN
      S_PARITY: w_line = r_par;
`else
      S_PARITY: w_line = 1'b1;
`endif
      S_STOP:   w_line = 1'b1;
      default:  w_line = 1'b1;
    endcase
  end

  // Shifter state register and registered serial output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div_cnt <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_bit_div <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_div <= w_bit_div_nxt;
      r_tx      <= w_line;
    end
  end

  // Divisor register; a frame in flight keeps its own latched copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div <= DEFAULT_DIV;
    end else if (w_sel && write && (w_ofs == OFS_DIV)) begin
      r_div <= wdata;
    end else begin
      r_div <= r_div;
    end
  end

  // Sticky overflow flag; a same-cycle overflow beats a software clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // STATUS byte assembly.
  always_comb begin
    w_status           = 8'h00;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_BUSY]  = w_busy;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_PAR]   = PARITY_BUILD;
  end

  // Read mux: follows the address combinationally, zero outside the map.
  always_comb begin
    rdata = 8'h00;
    if (w_sel) begin
      case (w_ofs)
        OFS_STATUS: rdata = w_status;
        OFS_DIV:    rdata = r_div;
        default:    rdata = 8'h00;
      endcase
    end else begin
      rdata = 8'h00;
    end
  end

endmodule

// File: tb/tb_cpu_serial_port.sv
// Directed bench for cpu_serial_port: register access, frame timing,
// FIFO overflow, full-FIFO push with simultaneous pop, reset mid-frame and
// (when SERIAL_PARITY_EN is defined) the parity bit.
module tb_cpu_serial_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic        write;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_oe;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef SERIAL_PARITY_EN
  localparam int         NBITS = 11;
  localparam logic [7:0] PAR   = 8'h10;
`else
  localparam int         NBITS = 10;
  localparam logic [7:0] PAR   = 8'h00;
`endif

  cpu_serial_port dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .write    (write),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdata_oe (rdata_oe),
    .tx       (tx)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Line monitor: decodes frames using the divisor the bench last programmed.
  int          mon_div = 3;
  bit          mon_act = 1'b0;
  int          mon_cnt;
  int          mon_t0;
  logic [10:0] mon_bits;
  logic [10:0] fr_q[$];
  int          ft_q[$];

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      mon_act = 1'b0;
    end else begin
      if (!mon_act && tx === 1'b0) begin
        mon_act  = 1'b1;
        mon_cnt  = 0;
        mon_bits = 11'd0;
        mon_t0   = cyc;
      end
      if (mon_act) begin
        if (mon_cnt % (mon_div + 1) == 0) mon_bits[mon_cnt / (mon_div + 1)] = tx;
        mon_cnt++;
        if (mon_cnt == NBITS * (mon_div + 1)) begin
          mon_act = 1'b0;
          fr_q.push_back(mon_bits);
          ft_q.push_back(mon_t0);
        end
      end
    end
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = 11'd0;
    f[8:1] = d;
`ifdef SERIAL_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clock);
    addr  = a;
    wdata = d;
    write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (fr_q.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    ok = (fr_q.size() >= n);
  endtask

  task automatic clear_mon(input int div);
    mon_div = div;
    fr_q.delete();
    ft_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; write = 1'b0; addr = 12'hFF1; wdata = 8'h00;
    repeat (3) @(negedge clock);
    n_checks++;
    if (tx !== 1'b1 || rdata_oe !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: tx=%b oe=%b expected tx=1 oe=0", tx, rdata_oe);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rdata !== (8'h02 | PAR)) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", rdata, 8'h02 | PAR);
    end
    n_checks++;
    if (rdata_oe !== 1'b1 || tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_oe_tx: oe=%b tx=%b expected 1 1", rdata_oe, tx);
    end
    addr = 12'hFF2; #1;
    n_checks++;
    if (rdata !== 8'h03) begin
      n_fail++; $display("FAIL reset_div: got %h expected 03", rdata);
    end
    addr = 12'hFF0; #1;
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++; $display("FAIL read_txdata: got %h expected 00", rdata);
    end
    addr = 12'hFF7; #1;
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++; $display("FAIL read_unmapped: got %h expected 00", rdata);
    end
    addr = 12'hEF1; #1;
    n_checks++;
    if (rdata_oe !== 1'b0) begin
      n_fail++; $display("FAIL oe_unselected: got %b expected 0", rdata_oe);
    end
  endtask

  task automatic test_regs();
    bus_write(12'hFF2, 8'h5A);
    addr = 12'hFF2; #1;
    n_checks++;
    if (rdata !== 8'h5A) begin
      n_fail++; $display("FAIL div_rw: got %h expected 5a", rdata);
    end
    bus_write(12'hFF9, 8'h77);
    addr = 12'hFF2; #1;
    n_checks++;
    if (rdata !== 8'h5A) begin
      n_fail++; $display("FAIL div_unmapped_write: got %h expected 5a", rdata);
    end
  endtask

  task automatic test_frame_div0();
    logic [10:0] exp;
    int          n_busy;
    bit          ok;
    exp    = exp_frame(8'hA5);
    n_busy = 0;
    ok     = 1'b1;
    bus_write(12'hFF2, 8'h00);
    clear_mon(0);
    bus_write(12'hFF0, 8'hA5);
    addr = 12'hFF1;
    for (int i = 0; i < NBITS + 2; i++) begin
      @(negedge clock);
      if (rdata[2] === 1'b1) n_busy++;
      if (i == 0 && (tx !== 1'b1 || rdata[2] !== 1'b1)) ok = 1'b0;
      if (i >= 1 && i <= NBITS && tx !== exp[i-1]) begin
        n_fail++; $display("FAIL a5_bit%0d: got %b expected %b", i - 1, tx, exp[i-1]);
      end
      if (i >= 1 && i <= NBITS) n_checks++;
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL a5_latency: tx/busy one cycle after write not 1/1");
    end
    n_checks++;
    if (n_busy != NBITS) begin
      n_fail++; $display("FAIL a5_busy_len: got %0d expected %0d", n_busy, NBITS);
    end
  endtask

  task automatic test_burst();
    bit ok;
    bus_write(12'hFF2, 8'h01);
    clear_mon(1);
    addr = 12'hFF0;
    // The first pop overlaps the second write, so six writes are needed to overflow.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      wdata = 8'(i + 1);
      write = 1'b1;
    end
    @(negedge clock);
    write = 1'b0;
    addr  = 12'hFF1; #1;
    n_checks++;
    if (rdata !== (8'h0D | PAR)) begin
      n_fail++; $display("FAIL burst_status: got %h expected %h", rdata, 8'h0D | PAR);
    end
    bus_write(12'hFF1, 8'h08);
    addr = 12'hFF1; #1;
    n_checks++;
    if (rdata !== (8'h05 | PAR)) begin
      n_fail++; $display("FAIL ovf_clear: got %h expected %h", rdata, 8'h05 | PAR);
    end
    wait_frames(5, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL burst_timeout: got %0d frames expected 5", fr_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (fr_q[k] !== exp_frame(8'(k + 1))) begin
          n_fail++; $display("FAIL burst_frame%0d: got %h expected %h", k, fr_q[k], exp_frame(8'(k + 1)));
        end
        if (k > 0) begin
          n_checks++;
          if (ft_q[k] - ft_q[k-1] != NBITS * 2) begin
            n_fail++; $display("FAIL burst_gap%0d: got %0d expected %0d", k, ft_q[k] - ft_q[k-1], NBITS * 2);
          end
        end
      end
    end
    repeat (60) @(negedge clock);
    n_checks++;
    if (fr_q.size() != 5) begin
      n_fail++; $display("FAIL burst_dropped: got %0d frames expected 5", fr_q.size());
    end
    #1;
    n_checks++;
    if (rdata !== (8'h02 | PAR)) begin
      n_fail++; $display("FAIL burst_idle_status: got %h expected %h", rdata, 8'h02 | PAR);
    end
  endtask

  task automatic test_pop_full();
    bit ok;
    bus_write(12'hFF2, 8'h00);
    clear_mon(0);
    addr = 12'hFF0;
    // Bytes 1..5 fill the FIFO behind the first frame; byte 6 lands on the
    // edge where the first STOP ends and the next byte is popped.
    for (int i = 0; i <= NBITS + 1; i++) begin
      @(negedge clock);
      write = (i < 5) || (i == NBITS + 1);
      wdata = (i < 5) ? 8'(8'h11 * (i + 1)) : 8'h66;
    end
    @(negedge clock);
    write = 1'b0;
    addr  = 12'hFF1; #1;
    n_checks++;
    if (rdata !== (8'h05 | PAR)) begin
      n_fail++; $display("FAIL popfull_status: got %h expected %h", rdata, 8'h05 | PAR);
    end
    wait_frames(6, 300, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL popfull_timeout: got %0d frames expected 6", fr_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (fr_q[k] !== exp_frame(8'(8'h11 * (k + 1)))) begin
          n_fail++; $display("FAIL popfull_frame%0d: got %h expected %h", k, fr_q[k], exp_frame(8'(8'h11 * (k + 1))));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_low;
    n_low = 0;
    bus_write(12'hFF2, 8'h00);
    clear_mon(0);
    bus_write(12'hFF0, 8'h00);
    bus_write(12'hFF0, 8'h33);
    repeat (2) @(negedge clock);
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++; $display("FAIL midframe_tx: got %b expected 0", tx);
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx: got %b expected 1", tx);
    end
    @(negedge clock);
    reset = 1'b0;
    addr  = 12'hFF1; #1;
    n_checks++;
    if (rdata !== (8'h02 | PAR)) begin
      n_fail++; $display("FAIL reset_mid_status: got %h expected %h", rdata, 8'h02 | PAR);
    end
    addr = 12'hFF2; #1;
    n_checks++;
    if (rdata !== 8'h03) begin
      n_fail++; $display("FAIL reset_mid_div: got %h expected 03", rdata);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) n_low++;
    end
    n_checks++;
    if (n_low != 0 || fr_q.size() != 0) begin
      n_fail++; $display("FAIL reset_discard: low cycles %0d frames %0d expected 0 0", n_low, fr_q.size());
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    bit ok;
    bus_write(12'hFF2, 8'h00);
    clear_mon(0);
    bus_write(12'hFF0, 8'h07);
    addr = 12'hFF1; #1;
    n_checks++;
    if (rdata[4] !== 1'b1) begin
      n_fail++; $display("FAIL parity_flag: got %b expected 1", rdata[4]);
    end
    wait_frames(1, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL parity_timeout: no frame");
    end else if (fr_q[0] !== 11'h60E) begin
      n_fail++; $display("FAIL parity_frame: got %h expected 60e", fr_q[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_frame_div0();
    test_burst();
    test_pop_full();
    test_reset_mid();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
